// File: rtl/enemy_manager.sv
// Eight-slot enemy manager: spawn/kill bookkeeping, per-frame chase and spin,
// and a registered per-pixel hit test feeding the enemy sprite ROM stage.
module enemy_manager #(
    parameter int E_SIZE    = 36,
    parameter int SPEED     = 2,
    parameter int ANGLE_DIV = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        frame_start,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    input  logic        spawn_valid,
    output logic        spawn_ready,
    input  logic [9:0]  spawn_x,
    input  logic [9:0]  spawn_y,
    input  logic [1:0]  spawn_type,
    output logic [2:0]  spawn_idx,
    input  logic        kill_valid,
    input  logic [2:0]  kill_idx,
    output logic [7:0]  is_enemy_in_pixel,
    output logic [7:0]  is_enemy_active,
    output logic [47:0] enemy_hc,
    output logic [47:0] enemy_vc,
    output logic [31:0] enemy_angle,
    output logic [15:0] enemy_type,
    output logic [3:0]  active_count
);

    localparam int         DIV_W      = (ANGLE_DIV > 1) ? $clog2(ANGLE_DIV) : 1;
    localparam logic [9:0] SPEED_STEP = 10'(SPEED);
    localparam logic [10:0] SIZE_EXT  = 11'(E_SIZE);

    logic [7:0]       active;
    logic [2:0]       free_idx;
    logic             spawn_fire;
    logic             angle_tick;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [2:0]       spawn_idx_reg;

    // Move one axis toward the target by at most SPEED, never past it.
    function automatic logic [9:0] step_toward(input logic [9:0] pos, input logic [9:0] target);
        logic [9:0] diff;
        logic [9:0] result;
        diff   = '0;
        result = pos;
        if (pos < target) begin
            diff   = target - pos;
            result = pos + ((diff < SPEED_STEP) ? diff : SPEED_STEP);
        end else if (pos > target) begin
            diff   = pos - target;
            result = pos - ((diff < SPEED_STEP) ? diff : SPEED_STEP);
        end
        return result;
    endfunction

    // Lowest-index free slot, taken from the registered occupancy only.
    always_comb begin
        free_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!active[i]) begin
                free_idx = 3'(i);
            end
        end
    end

    assign spawn_ready = ~&active;
    assign spawn_fire  = spawn_valid && spawn_ready;
    assign angle_tick  = frame_start && (div_cnt_reg == DIV_W'(ANGLE_DIV - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            div_cnt_reg   <= '0;
            spawn_idx_reg <= '0;
        end else begin
            if (frame_start) begin
                div_cnt_reg <= angle_tick ? '0 : div_cnt_reg + DIV_W'(1);
            end
            if (spawn_fire) begin
                spawn_idx_reg <= free_idx;
            end
        end
    end

    assign spawn_idx = spawn_idx_reg;

    always_comb begin
        active_count = '0;
        for (int i = 0; i < 8; i++) begin
            active_count = active_count + {3'b000, active[i]};
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : gen_slot
        logic        active_reg;
        logic [9:0]  x_reg;
        logic [9:0]  y_reg;
        logic [3:0]  angle_reg;
        logic [1:0]  type_reg;
        logic        in_reg;
        logic [5:0]  hc_off_reg;
        logic [5:0]  vc_off_reg;

        logic        take;
        logic        kill;
        logic [10:0] x_end;
        logic [10:0] y_end;
        logic        hit;
        logic [5:0]  hc_off;
        logic [5:0]  vc_off;

        assign take = spawn_fire && (free_idx == 3'(gi));
        assign kill = kill_valid && (kill_idx == 3'(gi)) && active_reg;

        // Window end at 11 bits so sprites near the right/bottom edge never wrap.
        assign x_end  = {1'b0, x_reg} + SIZE_EXT;
        assign y_end  = {1'b0, y_reg} + SIZE_EXT;
        assign hit    = active_reg && (hc >= x_reg) && ({1'b0, hc} < x_end)
                                   && (vc >= y_reg) && ({1'b0, vc} < y_end);
        assign hc_off = hc[5:0] - x_reg[5:0];
        assign vc_off = vc[5:0] - y_reg[5:0];

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                active_reg <= 1'b0;
                x_reg      <= '0;
                y_reg      <= '0;
                angle_reg  <= '0;
                type_reg   <= '0;
                in_reg     <= 1'b0;
                hc_off_reg <= '0;
                vc_off_reg <= '0;
            end else begin
                in_reg     <= hit;
                hc_off_reg <= hit ? hc_off : 6'd0;
                vc_off_reg <= hit ? vc_off : 6'd0;

                // A freshly spawned or killed slot skips this frame's motion.
                if (take) begin
                    active_reg <= 1'b1;
                    x_reg      <= spawn_x;
                    y_reg      <= spawn_y;
                    type_reg   <= spawn_type;
                    angle_reg  <= '0;
                end else if (kill) begin
                    active_reg <= 1'b0;
                end else if (frame_start && active_reg) begin
                    x_reg <= step_toward(x_reg, player_x);
                    y_reg <= step_toward(y_reg, player_y);
                    if (angle_tick) begin
                        angle_reg <= angle_reg + 4'd1;
                    end
                end
            end
        end

        assign active[gi]                = active_reg;
        assign is_enemy_active[gi]       = active_reg;
        assign is_enemy_in_pixel[gi]     = in_reg;
        assign enemy_hc[6*gi +: 6]       = hc_off_reg;
        assign enemy_vc[6*gi +: 6]       = vc_off_reg;
        assign enemy_angle[4*gi +: 4]    = angle_reg;
        assign enemy_type[2*gi +: 2]     = type_reg;
    end

endmodule

// File: tb/tb_enemy_manager.sv
// Bench for enemy_manager: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a slot-level reference model.
module tb_enemy_manager;
    localparam int E_SIZE    = 36;
    localparam int SPEED     = 2;
    localparam int ANGLE_DIV = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [9:0]  hc, vc, player_x, player_y, spawn_x, spawn_y;
    logic        frame_start, spawn_valid, kill_valid;
    logic [1:0]  spawn_type;
    logic [2:0]  kill_idx;
    logic        spawn_ready;
    logic [2:0]  spawn_idx;
    logic [7:0]  is_enemy_in_pixel, is_enemy_active;
    logic [47:0] enemy_hc, enemy_vc;
    logic [31:0] enemy_angle;
    logic [15:0] enemy_type;
    logic [3:0]  active_count;

    enemy_manager #(.E_SIZE(E_SIZE), .SPEED(SPEED), .ANGLE_DIV(ANGLE_DIV)) dut (
        .CLK(CLK), .RST_N(RST_N), .hc(hc), .vc(vc), .frame_start(frame_start),
        .player_x(player_x), .player_y(player_y),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_type(spawn_type), .spawn_idx(spawn_idx),
        .kill_valid(kill_valid), .kill_idx(kill_idx),
        .is_enemy_in_pixel(is_enemy_in_pixel), .is_enemy_active(is_enemy_active),
        .enemy_hc(enemy_hc), .enemy_vc(enemy_vc), .enemy_angle(enemy_angle),
        .enemy_type(enemy_type), .active_count(active_count)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: plain per-slot records plus a frame counter.
    int m_active[8], m_x[8], m_y[8], m_angle[8], m_type[8];
    int m_frames, m_sidx;
    int e_in[8], e_hc[8], e_vc[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int count_active();
        int c = 0;
        for (int i = 0; i < 8; i++) c += m_active[i];
        return c;
    endfunction

    function automatic int clampi(input int d);
        if (d > SPEED) return SPEED;
        if (d < -SPEED) return -SPEED;
        return d;
    endfunction

    task automatic model_edge();
        int slot, killed, cnt;
        bit tick;
        if (!RST_N) begin
            for (int i = 0; i < 8; i++) begin
                m_active[i] = 0; m_x[i] = 0; m_y[i] = 0; m_angle[i] = 0; m_type[i] = 0;
                e_in[i] = 0; e_hc[i] = 0; e_vc[i] = 0;
            end
            m_frames = 0;
            m_sidx = 0;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            e_in[i] = (m_active[i] != 0) && int'(hc) >= m_x[i] && int'(hc) < m_x[i] + E_SIZE
                      && int'(vc) >= m_y[i] && int'(vc) < m_y[i] + E_SIZE;
            e_hc[i] = e_in[i] ? int'(hc) - m_x[i] : 0;
            e_vc[i] = e_in[i] ? int'(vc) - m_y[i] : 0;
        end
        cnt = count_active();
        slot = -1;
        if (spawn_valid && cnt < 8) begin
            for (int i = 7; i >= 0; i--) if (m_active[i] == 0) slot = i;
        end
        killed = (kill_valid && m_active[kill_idx] != 0) ? int'(kill_idx) : -1;
        tick = 0;
        if (frame_start) begin
            tick = (m_frames % ANGLE_DIV) == ANGLE_DIV - 1;
            m_frames++;
        end
        for (int i = 0; i < 8; i++) begin
            if (i == slot) begin
                m_active[i] = 1; m_x[i] = spawn_x; m_y[i] = spawn_y;
                m_type[i] = spawn_type; m_angle[i] = 0;
            end else if (i == killed) begin
                m_active[i] = 0;
            end else if (frame_start && m_active[i] != 0) begin
                m_x[i] += clampi(int'(player_x) - m_x[i]);
                m_y[i] += clampi(int'(player_y) - m_y[i]);
                if (tick) m_angle[i] = (m_angle[i] + 1) % 16;
            end
        end
        if (slot >= 0) m_sidx = slot;
    endtask

    task automatic compare_all();
        logic [7:0]  ea, ei;
        logic [47:0] eh, ev;
        logic [31:0] eang;
        logic [15:0] et;
        for (int i = 0; i < 8; i++) begin
            ea[i] = m_active[i] != 0;
            ei[i] = e_in[i] != 0;
            eh[6*i +: 6] = 6'(e_hc[i]);
            ev[6*i +: 6] = 6'(e_vc[i]);
            eang[4*i +: 4] = 4'(m_angle[i]);
            et[2*i +: 2] = 2'(m_type[i]);
        end
        check("spawn_ready", 64'(spawn_ready), 64'(count_active() < 8));
        check("spawn_idx", 64'(spawn_idx), 64'(m_sidx));
        check("is_enemy_active", 64'(is_enemy_active), 64'(ea));
        check("active_count", 64'(active_count), 64'(count_active()));
        check("enemy_angle", 64'(enemy_angle), 64'(eang));
        check("enemy_type", 64'(enemy_type), 64'(et));
        check("is_enemy_in_pixel", 64'(is_enemy_in_pixel), 64'(ei));
        check("enemy_hc", 64'(enemy_hc), 64'(eh));
        check("enemy_vc", 64'(enemy_vc), 64'(ev));
    endtask

    // One clock: model sees pre-edge inputs, outputs sampled 1 time unit after the edge.
    task automatic cycle();
        model_edge();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic idle();
        spawn_valid = 0; kill_valid = 0; frame_start = 0; RST_N = 1;
    endtask

    task automatic do_spawn(input int x, input int y, input int t);
        spawn_valid = 1; spawn_x = 10'(x); spawn_y = 10'(y); spawn_type = 2'(t);
        cycle();
        $display("[TB] spawn (%0d,%0d,type %0d) -> idx %0d ready %0d", x, y, t, spawn_idx, spawn_ready);
        spawn_valid = 0;
    endtask

    task automatic do_kill(input int k);
        kill_valid = 1; kill_idx = 3'(k);
        cycle();
        $display("[TB] kill %0d -> active %02h", k, is_enemy_active);
        kill_valid = 0;
    endtask

    task automatic do_reset();
        RST_N = 0;
        cycle();
        $display("[TB] reset -> active %02h ready %0d", is_enemy_active, spawn_ready);
        RST_N = 1;
    endtask

    task automatic probe(input int h, input int v);
        hc = 10'(h); vc = 10'(v);
        cycle();
        $display("[TB] probe (%0d,%0d) -> in %02h hc0 %0d vc0 %0d", h, v, is_enemy_in_pixel,
                 enemy_hc[5:0], enemy_vc[5:0]);
    endtask

    task automatic frame();
        frame_start = 1;
        cycle();
        frame_start = 0;
    endtask

    initial begin
        RST_N = 0; hc = 0; vc = 0; frame_start = 0; player_x = 100; player_y = 50;
        spawn_valid = 0; spawn_x = 0; spawn_y = 0; spawn_type = 0; kill_valid = 0; kill_idx = 0;
        do_reset();
        do_reset();
        check("rst_active", 64'(is_enemy_active), 64'h0);
        check("rst_ready", 64'(spawn_ready), 64'h1);
        check("rst_count", 64'(active_count), 64'h0);

        // Spawn then hit test
        do_spawn(100, 50, 2);
        check("spawn_idx0", 64'(spawn_idx), 64'h0);
        check("spawn_active", 64'(is_enemy_active), 64'h01);
        check("spawn_type", 64'(enemy_type[1:0]), 64'h2);
        probe(110, 85);
        check("hit_in", 64'(is_enemy_in_pixel[0]), 64'h1);
        check("hit_hc", 64'(enemy_hc[5:0]), 64'd10);
        check("hit_vc", 64'(enemy_vc[5:0]), 64'd35);
        probe(136, 85);
        check("edge_in", 64'(is_enemy_in_pixel[0]), 64'h0);
        check("edge_hc", 64'(enemy_hc[5:0]), 64'h0);

        // Movement toward (103,50) with no overshoot
        player_x = 103; player_y = 50;
        frame(); probe(103, 50);
        check("move1_hc", 64'(enemy_hc[5:0]), 64'd1);
        frame(); probe(103, 50);
        check("move2_hc", 64'(enemy_hc[5:0]), 64'd0);
        check("move2_in", 64'(is_enemy_in_pixel[0]), 64'h1);
        frame(); probe(102, 50);
        check("move3_left", 64'(is_enemy_in_pixel[0]), 64'h0);
        probe(103, 50);
        check("move3_in", 64'(is_enemy_in_pixel[0]), 64'h1);

        // Rotation
        do_reset();
        player_x = 200; player_y = 200;
        do_spawn(200, 200, 1);
        for (int f = 1; f <= 64; f++) begin
            frame();
            idle();
            cycle();
            if (f == 3)  check("rot3", 64'(enemy_angle[3:0]), 64'd0);
            if (f == 4)  check("rot4", 64'(enemy_angle[3:0]), 64'd1);
            if (f == 63) check("rot63", 64'(enemy_angle[3:0]), 64'd15);
            if (f == 64) check("rot64", 64'(enemy_angle[3:0]), 64'd0);
        end

        // Fill and overflow
        do_reset();
        for (int i = 0; i < 8; i++) do_spawn(40 * i, 10 * i, i % 4);
        check("full_count", 64'(active_count), 64'd8);
        check("full_ready", 64'(spawn_ready), 64'h0);
        do_spawn(500, 500, 3);
        check("overflow_idx", 64'(spawn_idx), 64'd7);
        check("overflow_count", 64'(active_count), 64'd8);
        do_kill(3);
        check("kill_ready", 64'(spawn_ready), 64'h1);
        check("kill_active", 64'(is_enemy_active), 64'hF7);
        do_spawn(300, 300, 1);
        check("refill_idx", 64'(spawn_idx), 64'd3);

        // Simultaneous spawn and kill
        do_kill(5);
        kill_valid = 1; kill_idx = 2;
        do_spawn(60, 70, 2);
        kill_valid = 0;
        check("sk_idx", 64'(spawn_idx), 64'd5);
        check("sk_active", 64'(is_enemy_active), 64'hFB);
        check("sk_count", 64'(active_count), 64'd7);

        // Randomized traffic
        idle();
        for (int n = 0; n < 3000; n++) begin
            int s;
            RST_N       = ($urandom_range(0, 299) != 0);
            spawn_valid = ($urandom_range(0, 2) == 0);
            spawn_x     = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(960, 1023))
                                                      : 10'($urandom_range(0, 700));
            spawn_y     = 10'($urandom_range(0, 1023));
            spawn_type  = 2'($urandom);
            kill_valid  = ($urandom_range(0, 4) == 0);
            kill_idx    = 3'($urandom);
            frame_start = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) begin
                player_x = 10'($urandom);
                player_y = 10'($urandom);
            end
            s = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 0) begin
                hc = 10'($urandom);
                vc = 10'($urandom);
            end else begin
                hc = 10'(m_x[s] + int'($urandom_range(0, 39)) - 2);
                vc = 10'(m_y[s] + int'($urandom_range(0, 39)) - 2);
            end
            cycle();
        end

        // Reset wins over frame, spawn and kill
        idle();
        do_spawn(10, 10, 3);
        do_spawn(20, 20, 2);
        probe(15, 15);
        RST_N = 0; frame_start = 1; spawn_valid = 1; kill_valid = 1; kill_idx = 0;
        cycle();
        idle();
        check("mrst_active", 64'(is_enemy_active), 64'h0);
        check("mrst_pixel", 64'(is_enemy_in_pixel), 64'h0);
        check("mrst_hc", 64'(enemy_hc), 64'h0);
        check("mrst_vc", 64'(enemy_vc), 64'h0);
        check("mrst_angle", 64'(enemy_angle), 64'h0);
        check("mrst_type", 64'(enemy_type), 64'h0);
        check("mrst_count", 64'(active_count), 64'h0);
        check("mrst_idx", 64'(spawn_idx), 64'h0);
        check("mrst_ready", 64'(spawn_ready), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
